// File: rtl/mfp_ahb_input_capture_pkg.sv
// Shared constants, register decode and types for the board-input AHB slave.
// The register offsets are relative to the block base.
package mfp_ahb_input_capture_pkg;

    localparam logic [1:0]  HTRANS_IDLE        = 2'b00;
    localparam logic [11:0] H_INCAP_SW_ADDR    = 12'h000;
    localparam logic [11:0] H_INCAP_PB_ADDR    = 12'h004;
    localparam logic [11:0] H_INCAP_EDGE_ADDR  = 12'h008;
    localparam logic [11:0] H_INCAP_IRQEN_ADDR = 12'h00C;
    localparam int          MFP_N_SW           = 16;
    localparam int          MFP_N_PB           = 5;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_SW,
        SEL_PB,
        SEL_EDGE,
        SEL_IRQEN
    } reg_sel_e;

    // Byte lanes are ignored; anything outside the four words is unmapped.
    function automatic reg_sel_e reg_decode(input logic [11:0] off);
        reg_sel_e s;
        unique case (off & 12'hFFC)
            H_INCAP_SW_ADDR:    s = SEL_SW;
            H_INCAP_PB_ADDR:    s = SEL_PB;
            H_INCAP_EDGE_ADDR:  s = SEL_EDGE;
            H_INCAP_IRQEN_ADDR: s = SEL_IRQEN;
            default:            s = SEL_NONE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mfp_ahb_input_capture_if.sv
// AHB-Lite slave-side bus bundle for the input-capture block.
// HCLK/HRESETn stay as plain ports on the modules.
interface mfp_ahb_input_capture_if;

    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HWDATA,
        input  HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HWDATA,
        output HRDATA
    );

endinterface

// File: rtl/mfp_ahb_debounce.sv
// One-bit 2-FF synchroniser followed by a stable-count debouncer.
// The output only moves after DEBOUNCE_CYCLES consecutive differing samples.
module mfp_ahb_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic resetn,
    input  logic din,
    output logic dout
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta_q;
    logic          sync_q;
    logic          dout_q;
    logic          dout_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d  = '0;
        dout_d = dout_q;
        if (sync_q != dout_q) begin
            if (cnt_q == CNT_LAST) dout_d = sync_q;
            else                   cnt_d  = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            dout_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            dout_q <= dout_d;
            cnt_q  <= cnt_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/mfp_ahb_input_capture.sv
// AHB-Lite read-side board peripheral: debounced switches and buttons,
// sticky W1C button-press flags and a level IRQ.
module mfp_ahb_input_capture
    import mfp_ahb_input_capture_pkg::*;
#(
    parameter int N_SW            = MFP_N_SW,
    parameter int N_PB            = MFP_N_PB,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    mfp_ahb_input_capture_if.slave ahb,
    input  logic [N_SW-1:0]        IO_Switch,
    input  logic [N_PB-1:0]        IO_PB,
    output logic                   IRQ
);

    logic [N_SW-1:0] sw_db;
    logic [N_PB-1:0] pb_db;
    logic [N_PB-1:0] pb_prev_q;
    logic [N_PB-1:0] edge_q;
    logic [N_PB-1:0] edge_d;
    logic [N_PB-1:0] en_q;
    logic [N_PB-1:0] en_d;
    logic [N_PB-1:0] clr;
    logic            acc;
    reg_sel_e        sel;
    reg_sel_e        sel_q;
    logic            wr_q;
    logic [31:0]     rdata_q;
    logic [31:0]     rdata_d;
    logic            irq_q;
    logic            unused_bits;

    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        mfp_ahb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk    (HCLK),
            .resetn (HRESETn),
            .din    (IO_Switch[i]),
            .dout   (sw_db[i])
        );
    end

    for (genvar i = 0; i < N_PB; i++) begin : g_pb
        mfp_ahb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk    (HCLK),
            .resetn (HRESETn),
            .din    (IO_PB[i]),
            .dout   (pb_db[i])
        );
    end

    assign acc         = ahb.HSEL && (ahb.HTRANS != HTRANS_IDLE);
    assign sel         = reg_decode(ahb.HADDR[11:0]);
    assign unused_bits = ^{ahb.HADDR[31:12], ahb.HWDATA[31:N_PB]};

    // A new edge is OR'd in after the clear so a colliding press survives.
    always_comb begin
        clr  = '0;
        en_d = en_q;
        if (wr_q && sel_q == SEL_EDGE)  clr  = ahb.HWDATA[N_PB-1:0];
        if (wr_q && sel_q == SEL_IRQEN) en_d = ahb.HWDATA[N_PB-1:0];
        edge_d = (edge_q & ~clr) | (pb_db & ~pb_prev_q);
    end

    // Reads see the next-state values, so a write directly ahead is visible.
    always_comb begin
        rdata_d = rdata_q;
        if (acc && !ahb.HWRITE) begin
            unique case (sel)
                SEL_SW:    rdata_d = 32'(sw_db);
                SEL_PB:    rdata_d = 32'(pb_db);
                SEL_EDGE:  rdata_d = 32'(edge_d);
                SEL_IRQEN: rdata_d = 32'(en_d);
                default:   rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_q      <= 1'b0;
            sel_q     <= SEL_NONE;
            pb_prev_q <= '0;
            edge_q    <= '0;
            en_q      <= '0;
            rdata_q   <= '0;
            irq_q     <= 1'b0;
        end else begin
            wr_q      <= acc && ahb.HWRITE;
            sel_q     <= sel;
            pb_prev_q <= pb_db;
            edge_q    <= edge_d;
            en_q      <= en_d;
            rdata_q   <= rdata_d;
            irq_q     <= |(edge_q & en_q);
        end
    end

    assign ahb.HRDATA = rdata_q;
    assign IRQ        = irq_q;

endmodule

// File: tb/tb_mfp_ahb_input_capture.sv
// Bench for the input-capture slave: directed scenarios plus random
// stimulus against a run-length reference model.
module tb_mfp_ahb_input_capture;

    localparam int D    = 4;
    localparam int NSW  = 16;
    localparam int NPB  = 5;
    localparam int NB   = NSW + NPB;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [NSW-1:0] IO_Switch = '0;
    logic [NPB-1:0] IO_PB = '0;
    logic           IRQ;
    int             checks = 0;
    int             failures = 0;
    logic [31:0]    rd;

    mfp_ahb_input_capture_if ahb ();

    mfp_ahb_input_capture #(
        .N_SW            (NSW),
        .N_PB            (NPB),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .HCLK      (clk),
        .HRESETn   (rst_n),
        .ahb       (ahb),
        .IO_Switch (IO_Switch),
        .IO_PB     (IO_PB),
        .IRQ       (IRQ)
    );

    always #5 clk = ~clk;

    // Reference model: a bit's debounced value follows its input once the
    // input (seen two samples late) has held one value for D samples.
    logic [NB-1:0]  m_h1, m_h2, m_db, m_rv, m_s, m_pre;
    int             m_run [NB];
    logic [NPB-1:0] m_pbprev, m_edge, m_en, m_rise, m_clr;
    logic           m_wr, m_irq;
    logic [11:0]    m_wa;
    logic [31:0]    m_rd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_h1 = '0; m_h2 = '0; m_db = '0; m_rv = '0;
            for (int i = 0; i < NB; i++) m_run[i] = 0;
            m_pbprev = '0; m_edge = '0; m_en = '0;
            m_wr = 1'b0; m_wa = '0; m_irq = 1'b0; m_rd = '0;
        end else begin
            m_irq = |(m_edge & m_en);
            m_pre = m_db;
            m_s   = m_h2;
            for (int i = 0; i < NB; i++) begin
                if (m_s[i] == m_rv[i]) begin
                    if (m_run[i] < D) m_run[i]++;
                end else begin
                    m_rv[i]  = m_s[i];
                    m_run[i] = 1;
                end
                if (m_run[i] >= D && m_db[i] != m_s[i]) m_db[i] = m_s[i];
            end
            m_h2 = m_h1;
            m_h1 = {IO_PB, IO_Switch};
            m_rise   = m_pre[NB-1:NSW] & ~m_pbprev;
            m_pbprev = m_pre[NB-1:NSW];
            m_clr = '0;
            if (m_wr && m_wa == 12'h008) m_clr = ahb.HWDATA[NPB-1:0];
            if (m_wr && m_wa == 12'h00C) m_en  = ahb.HWDATA[NPB-1:0];
            m_edge = (m_edge & ~m_clr) | m_rise;
            if (ahb.HSEL && ahb.HTRANS != 2'b00 && !ahb.HWRITE) begin
                case (ahb.HADDR[11:0] & 12'hFFC)
                    12'h000: m_rd = 32'(m_pre[NSW-1:0]);
                    12'h004: m_rd = 32'(m_pre[NB-1:NSW]);
                    12'h008: m_rd = 32'(m_edge);
                    12'h00C: m_rd = 32'(m_en);
                    default: m_rd = '0;
                endcase
            end
            m_wr = ahb.HSEL && ahb.HTRANS != 2'b00 && ahb.HWRITE;
            m_wa = ahb.HADDR[11:0] & 12'hFFC;
        end
    end

    task automatic bus_idle();
        ahb.HSEL   = 1'b0;
        ahb.HTRANS = 2'b00;
        ahb.HWRITE = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        ahb.HSEL = 1'b1; ahb.HTRANS = 2'b10; ahb.HWRITE = 1'b0; ahb.HADDR = a;
        @(negedge clk);
        bus_idle();
        d = ahb.HRDATA;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        ahb.HSEL = 1'b1; ahb.HTRANS = 2'b10; ahb.HWRITE = 1'b1; ahb.HADDR = a;
        @(negedge clk);
        bus_idle();
        ahb.HWDATA = d;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        IO_Switch = 16'hA5A5;
        IO_PB = '0;
        bus_idle();
        ahb.HADDR = '0; ahb.HWDATA = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (ahb.HRDATA !== 32'h0) begin
            failures++; $display("FAIL reset_hrdata got=%h exp=%h", ahb.HRDATA, 32'h0);
        end
        checks++;
        if (IRQ !== 1'b0) begin
            failures++; $display("FAIL reset_irq got=%b exp=0", IRQ);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        bus_read(32'h0, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++; $display("FAIL sw_before_debounce got=%h exp=%h", rd, 32'h0);
        end
        bus_read(32'h0, rd);
        checks++;
        if (rd !== 32'h0000A5A5) begin
            failures++; $display("FAIL sw_after_debounce got=%h exp=%h", rd, 32'h0000A5A5);
        end
    endtask

    task automatic test_glitch();
        @(negedge clk); IO_PB = 5'h01;
        repeat (3) @(negedge clk); IO_PB = 5'h00;
        repeat (8) @(negedge clk);
        bus_read(32'h4, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++; $display("FAIL glitch_pbval got=%h exp=%h", rd, 32'h0);
        end
        bus_read(32'h8, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++; $display("FAIL glitch_edge got=%h exp=%h", rd, 32'h0);
        end
    endtask

    task automatic test_press();
        @(negedge clk); IO_PB = 5'h04;
        repeat (10) @(negedge clk);
        bus_read(32'h4, rd);
        checks++;
        if (rd !== 32'h4) begin
            failures++; $display("FAIL press_pbval got=%h exp=%h", rd, 32'h4);
        end
        bus_read(32'h8, rd);
        checks++;
        if (rd !== 32'h4) begin
            failures++; $display("FAIL press_edge got=%h exp=%h", rd, 32'h4);
        end
        IO_PB = 5'h00;
        repeat (10) @(negedge clk);
        bus_read(32'h4, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++; $display("FAIL release_pbval got=%h exp=%h", rd, 32'h0);
        end
        bus_read(32'h8, rd);
        checks++;
        if (rd !== 32'h4) begin
            failures++; $display("FAIL release_edge got=%h exp=%h", rd, 32'h4);
        end
    endtask

    task automatic test_w1c_irq();
        bus_write(32'hC, 32'h4);
        checks++;
        if (IRQ !== 1'b0) begin
            failures++; $display("FAIL irq_not_early got=%b exp=0", IRQ);
        end
        @(negedge clk);
        checks++;
        if (IRQ !== 1'b1) begin
            failures++; $display("FAIL irq_on_enable got=%b exp=1", IRQ);
        end
        bus_write(32'h8, 32'h1);
        bus_read(32'h8, rd);
        checks++;
        if (rd !== 32'h4) begin
            failures++; $display("FAIL w1c_other_bit got=%h exp=%h", rd, 32'h4);
        end
        checks++;
        if (IRQ !== 1'b1) begin
            failures++; $display("FAIL irq_held got=%b exp=1", IRQ);
        end
        bus_write(32'h8, 32'h4);
        checks++;
        if (IRQ !== 1'b1) begin
            failures++; $display("FAIL irq_lag_clear got=%b exp=1", IRQ);
        end
        @(negedge clk);
        checks++;
        if (IRQ !== 1'b0) begin
            failures++; $display("FAIL irq_after_clear got=%b exp=0", IRQ);
        end
        bus_read(32'h8, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++; $display("FAIL w1c_cleared got=%h exp=%h", rd, 32'h0);
        end
    endtask

    // The clear's data phase ends on the same edge that sets the flag.
    task automatic test_collision();
        @(negedge clk); IO_PB = 5'h04;
        repeat (4) @(negedge clk);
        bus_write(32'h8, 32'h4);
        bus_read(32'h8, rd);
        checks++;
        if (rd !== 32'h4) begin
            failures++; $display("FAIL collision_edge got=%h exp=%h", rd, 32'h4);
        end
        IO_PB = 5'h00;
        repeat (10) @(negedge clk);
        bus_write(32'h8, 32'h4);
        bus_read(32'h8, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++; $display("FAIL collision_clear got=%h exp=%h", rd, 32'h0);
        end
    endtask

    task automatic test_bus();
        @(negedge clk);
        ahb.HSEL = 1'b1; ahb.HTRANS = 2'b00; ahb.HWRITE = 1'b1; ahb.HADDR = 32'hC;
        @(negedge clk);
        bus_idle(); ahb.HWDATA = 32'h1F;
        @(negedge clk);
        bus_read(32'hC, rd);
        checks++;
        if (rd !== 32'h4) begin
            failures++; $display("FAIL idle_write got=%h exp=%h", rd, 32'h4);
        end
        bus_read(32'h10, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++; $display("FAIL unmapped_read got=%h exp=%h", rd, 32'h0);
        end
        bus_write(32'h0, 32'hFFFF_FFFF);
        bus_read(32'h0, rd);
        checks++;
        if (rd !== 32'h0000A5A5) begin
            failures++; $display("FAIL ro_write got=%h exp=%h", rd, 32'h0000A5A5);
        end
        @(negedge clk);
        ahb.HSEL = 1'b1; ahb.HTRANS = 2'b10; ahb.HWRITE = 1'b1; ahb.HADDR = 32'hC;
        @(negedge clk);
        ahb.HWDATA = 32'h13; ahb.HWRITE = 1'b0;
        @(negedge clk);
        bus_idle();
        rd = ahb.HRDATA;
        checks++;
        if (rd !== 32'h13) begin
            failures++; $display("FAIL back_to_back got=%h exp=%h", rd, 32'h13);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        ahb.HSEL = 1'b1; ahb.HTRANS = 2'b10; ahb.HWRITE = 1'b1; ahb.HADDR = 32'hC;
        ahb.HWDATA = 32'h1F;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ahb.HRDATA !== 32'h0) begin
            failures++; $display("FAIL mid_reset_hrdata got=%h exp=%h", ahb.HRDATA, 32'h0);
        end
        @(negedge clk);
        bus_idle();
        @(negedge clk);
        rst_n = 1'b1;
        bus_read(32'hC, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++; $display("FAIL mid_reset_write got=%h exp=%h", rd, 32'h0);
        end
    endtask

    task automatic test_random();
        bit          prev_rd = 1'b0;
        bit          prev_wr = 1'b0;
        logic [31:0] wd = '0;
        logic [31:0] a;
        int          op;
        for (int it = 0; it < 600; it++) begin
            @(negedge clk);
            if (prev_rd) begin
                checks++;
                if (ahb.HRDATA !== m_rd) begin
                    failures++;
                    $display("FAIL rand_read it=%0d got=%h exp=%h", it, ahb.HRDATA, m_rd);
                end
            end
            checks++;
            if (IRQ !== m_irq) begin
                failures++; $display("FAIL rand_irq it=%0d got=%b exp=%b", it, IRQ, m_irq);
            end
            if ($urandom_range(0, 3) == 0) IO_Switch = NSW'($urandom);
            if ($urandom_range(0, 5) == 0) IO_PB = NPB'($urandom);
            ahb.HWDATA = prev_wr ? wd : $urandom;
            case ($urandom_range(0, 4))
                0:       a = 32'h0;
                1:       a = 32'h4;
                2:       a = 32'h8;
                3:       a = 32'hC;
                default: a = 32'h10;
            endcase
            op = $urandom_range(0, 3);
            prev_rd = 1'b0;
            prev_wr = 1'b0;
            ahb.HADDR = a;
            if (op == 0) begin
                ahb.HSEL = 1'($urandom); ahb.HTRANS = 2'b00; ahb.HWRITE = 1'($urandom);
            end else if (op == 1) begin
                ahb.HSEL = 1'b1; ahb.HTRANS = 2'b10; ahb.HWRITE = 1'b1;
                wd = $urandom; prev_wr = 1'b1;
            end else begin
                ahb.HSEL = 1'b1; ahb.HTRANS = 2'b10; ahb.HWRITE = 1'b0;
                prev_rd = 1'b1;
            end
        end
        @(negedge clk);
        bus_idle();
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_press();
        test_w1c_irq();
        test_collision();
        test_bus();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
